// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the 4-bit CPU sequencer.
//   - default opcode / address widths
//   - opcode encodings OP_NOP..OP_HLT
//   - ALU operation encodings
//   - FSM state encoding (state_e)
//   - strobe bundle (ctrl_t) produced by instr_decoder
package cpu_pkg;

    localparam int unsigned CPU_OPC_W   = 4;
    localparam int unsigned CPU_ADDR_W  = 4;
    localparam int unsigned CPU_STATE_W = 3;
    localparam int unsigned CPU_ALU_W   = 2;

    localparam logic [CPU_OPC_W-1:0] OP_NOP = 4'h0;
    localparam logic [CPU_OPC_W-1:0] OP_LDI = 4'h1;
    localparam logic [CPU_OPC_W-1:0] OP_ADD = 4'h2;
    localparam logic [CPU_OPC_W-1:0] OP_SUB = 4'h3;
    localparam logic [CPU_OPC_W-1:0] OP_OUT = 4'h4;
    localparam logic [CPU_OPC_W-1:0] OP_JMP = 4'h5;
    localparam logic [CPU_OPC_W-1:0] OP_JZ  = 4'h6;
    localparam logic [CPU_OPC_W-1:0] OP_HLT = 4'hF;

    localparam logic [CPU_ALU_W-1:0] ALU_PASS = 2'b00;
    localparam logic [CPU_ALU_W-1:0] ALU_ADD  = 2'b01;
    localparam logic [CPU_ALU_W-1:0] ALU_SUB  = 2'b10;

    typedef enum logic [CPU_STATE_W-1:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_HALT    = 3'd3,
        ST_WAIT    = 3'd4
    } state_e;

    typedef struct packed {
        logic                 ir_load;
        logic                 pc_inc;
        logic                 pc_load;
        logic                 acc_load;
        logic                 out_load;
        logic [CPU_ALU_W-1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: combinational strobe decode from FSM state, opcode and zero flag.
// Ports:
//   state_i     current sequencer state
//   opcode_i    IR[7:4]
//   zero_flag_i accumulator == 0 (only consulted for JZ in EXECUTE)
//   ctrl_o      strobe bundle (ir_load, pc_inc, pc_load, acc_load, out_load, alu_op)
module instr_decoder
    import cpu_pkg::*;
(
    input  state_e               state_i,
    input  logic [CPU_OPC_W-1:0] opcode_i,
    input  logic                 zero_flag_i,
    output ctrl_t                ctrl_o
);

    always_comb begin
        ctrl_o = CTRL_IDLE;
        case (state_i)
            ST_FETCH: ctrl_o.ir_load = 1'b1;
            ST_EXECUTE: begin
                case (opcode_i)
                    OP_LDI: begin
                        ctrl_o.alu_op   = ALU_PASS;
                        ctrl_o.acc_load = 1'b1;
                        ctrl_o.pc_inc   = 1'b1;
                    end
                    OP_ADD: begin
                        ctrl_o.alu_op   = ALU_ADD;
                        ctrl_o.acc_load = 1'b1;
                        ctrl_o.pc_inc   = 1'b1;
                    end
                    OP_SUB: begin
                        ctrl_o.alu_op   = ALU_SUB;
                        ctrl_o.acc_load = 1'b1;
                        ctrl_o.pc_inc   = 1'b1;
                    end
                    OP_OUT: begin
                        ctrl_o.out_load = 1'b1;
                        ctrl_o.pc_inc   = 1'b1;
                    end
                    OP_JMP: ctrl_o.pc_load = 1'b1;
                    // Only path where an input reaches a strobe without a register
                    OP_JZ: begin
                        ctrl_o.pc_load = zero_flag_i;
                        ctrl_o.pc_inc  = ~zero_flag_i;
                    end
                    // PC freezes on the HLT address
                    OP_HLT: ;
                    // NOP and the unassigned opcodes just advance
                    default: ctrl_o.pc_inc = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: FETCH/DECODE/EXECUTE sequencer for the 4-bit CPU.
// Owns the instruction register and the FSM; strobes come from instr_decoder.
// Ports:
//   clk, reset_n   rising-edge clock, async active-low reset
//   instr          ROM data at the current PC
//   zero_flag      accumulator == 0
//   step           single-step release (only with CTRL_STEP_EN)
//   ir_load, pc_inc, pc_load, acc_load, out_load   single-cycle strobes
//   operand        IR[3:0]: jump target and immediate
//   alu_op         00 PASS, 01 ADD, 10 SUB
//   halted, state  status / debug
// Build option: define CTRL_STEP_EN to add the step input and the WAIT state.
module control_unit
    import cpu_pkg::*;
#(
    parameter int unsigned OPC_W  = CPU_OPC_W,
    parameter int unsigned ADDR_W = CPU_ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [OPC_W+ADDR_W-1:0] instr,
    input  logic                   zero_flag,
`ifdef CTRL_STEP_EN
    input  logic                   step,
`endif
    output logic                   ir_load,
    output logic                   pc_inc,
    output logic                   pc_load,
    output logic [ADDR_W-1:0]      operand,
    output logic [CPU_ALU_W-1:0]   alu_op,
    output logic                   acc_load,
    output logic                   out_load,
    output logic                   halted,
    output logic [CPU_STATE_W-1:0] state
);

    localparam int unsigned IR_W = OPC_W + ADDR_W;

    state_e          state_q, state_d;
    logic [IR_W-1:0] ir_q, ir_d;
    ctrl_t           ctrl;

    // Next state and IR capture
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            ST_FETCH: begin
                ir_d    = instr;
                state_d = ST_DECODE;
            end
            ST_DECODE: state_d = ST_EXECUTE;
            ST_EXECUTE: begin
                if (ir_q[IR_W-1 -: OPC_W] == OPC_W'(OP_HLT)) begin
                    state_d = ST_HALT;
                end else begin
`ifdef CTRL_STEP_EN
                    state_d = ST_WAIT;
`else
                    state_d = ST_FETCH;
`endif
                end
            end
            ST_HALT: state_d = ST_HALT;
`ifdef CTRL_STEP_EN
            ST_WAIT: begin
                if (step) begin
                    state_d = ST_FETCH;
                end
            end
`endif
            default: state_d = ST_FETCH;
        endcase
    end

    // State and IR registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_FETCH;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    instr_decoder u_instr_decoder (
        .state_i     (state_q),
        .opcode_i    (CPU_OPC_W'(ir_q[IR_W-1 -: OPC_W])),
        .zero_flag_i (zero_flag),
        .ctrl_o      (ctrl)
    );

    // Reset parks the FSM in FETCH; hold the capture strobe low until release
    assign ir_load  = ctrl.ir_load & reset_n;
    assign pc_inc   = ctrl.pc_inc;
    assign pc_load  = ctrl.pc_load;
    assign acc_load = ctrl.acc_load;
    assign out_load = ctrl.out_load;
    assign alu_op   = ctrl.alu_op;
    assign operand  = ir_q[ADDR_W-1:0];
    assign halted   = (state_q == ST_HALT);
    assign state    = state_q;

endmodule

// File: tb/tb_control_unit.sv
`timescale 1ns/1ps
module tb_control_unit;

`ifdef CTRL_STEP_EN
    localparam int PER = 4;
`else
    localparam int PER = 3;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] instr;
    logic       zero_flag;
    logic       ir_load, pc_inc, pc_load, acc_load, out_load, halted;
    logic [3:0] operand;
    logic [1:0] alu_op;
    logic [2:0] state;
`ifdef CTRL_STEP_EN
    logic       step;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    control_unit dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .instr     (instr),
        .zero_flag (zero_flag),
`ifdef CTRL_STEP_EN
        .step      (step),
`endif
        .ir_load   (ir_load),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .operand   (operand),
        .alu_op    (alu_op),
        .acc_load  (acc_load),
        .out_load  (out_load),
        .halted    (halted),
        .state     (state)
    );

    // Surrounding datapath driven by the DUT strobes: ROM, PC, accumulator, output reg
    logic [7:0] rom [16];
    logic [3:0] pc_r, acc_r, out_r;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_r  <= 4'd0;
            acc_r <= 4'd0;
            out_r <= 4'd0;
        end else begin
            if (pc_load)     pc_r <= operand;
            else if (pc_inc) pc_r <= pc_r + 4'd1;
            if (acc_load) begin
                case (alu_op)
                    2'b00:   acc_r <= operand;
                    2'b01:   acc_r <= acc_r + operand;
                    2'b10:   acc_r <= acc_r - operand;
                    default: acc_r <= acc_r;
                endcase
            end
            if (out_load) out_r <= acc_r;
        end
    end

    assign instr     = rom[pc_r];
    assign zero_flag = (acc_r == 4'd0);

    // Instruction-level reference: phase 0 fetch, 1 decode, 2 execute, 3 halt, 4 wait
    int         m_phase;
    logic [7:0] m_ir;
    logic [3:0] m_pc, m_acc, m_out;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase <= 0;
            m_ir    <= 8'h00;
            m_pc    <= 4'd0;
            m_acc   <= 4'd0;
            m_out   <= 4'd0;
        end else begin
            case (m_phase)
                0: begin
                    m_ir    <= rom[m_pc];
                    m_phase <= 1;
                end
                1: m_phase <= 2;
                2: begin
                    if (m_ir[7:4] == 4'hF) m_phase <= 3;
                    else                   m_phase <= (PER == 4) ? 4 : 0;
                    if (m_ir[7:4] == 4'h1) m_acc <= m_ir[3:0];
                    if (m_ir[7:4] == 4'h2) m_acc <= m_acc + m_ir[3:0];
                    if (m_ir[7:4] == 4'h3) m_acc <= m_acc - m_ir[3:0];
                    if (m_ir[7:4] == 4'h4) m_out <= m_acc;
                    if (m_ir[7:4] == 4'h5 || (m_ir[7:4] == 4'h6 && m_acc == 4'd0))
                        m_pc <= m_ir[3:0];
                    else if (m_ir[7:4] != 4'hF)
                        m_pc <= m_pc + 4'd1;
                end
`ifdef CTRL_STEP_EN
                4: if (step) m_phase <= 0;
`endif
                default: m_phase <= m_phase;
            endcase
        end
    end

    // Expected outputs from the reference state
    logic [3:0] m_op;
    logic       e_exec, e_taken;
    logic [1:0] e_alu;
    assign m_op    = m_ir[7:4];
    assign e_exec  = (m_phase == 2);
    assign e_taken = e_exec && (m_op == 4'h5 || (m_op == 4'h6 && m_acc == 4'd0));
    assign e_alu   = !e_exec ? 2'b00 : (m_op == 4'h2) ? 2'b01 : (m_op == 4'h3) ? 2'b10 : 2'b00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ir_load",  32'(ir_load),  32'(reset_n && m_phase == 0));
            chk("pc_inc",   32'(pc_inc),   32'(e_exec && !e_taken && m_op != 4'hF));
            chk("pc_load",  32'(pc_load),  32'(e_taken));
            chk("acc_load", 32'(acc_load), 32'(e_exec && m_op >= 4'h1 && m_op <= 4'h3));
            chk("out_load", 32'(out_load), 32'(e_exec && m_op == 4'h4));
            chk("alu_op",   32'(alu_op),   32'(e_alu));
            chk("operand",  32'(operand),  32'(m_ir[3:0]));
            chk("halted",   32'(halted),   32'(m_phase == 3));
            chk("state",    32'(state),    32'(m_phase));
            chk("pc",       32'(pc_r),     32'(m_pc));
            chk("acc",      32'(acc_r),    32'(m_acc));
            chk("outreg",   32'(out_r),    32'(m_out));
        end
    end

    task automatic start();
        @(posedge clk);
        #2 reset_n = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b1;
    endtask

    task automatic fill(input logic [7:0] v);
        for (int a = 0; a < 16; a++) rom[a] = v;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
`ifdef CTRL_STEP_EN
        step = 1'b1;
`endif
        fill(8'h00);
        cyc(2);
        #1;
        chk("rst_state",   32'(state),   32'd0);
        chk("rst_ir_load", 32'(ir_load), 32'd0);
        chk("rst_operand", 32'(operand), 32'd0);
        chk("rst_halted",  32'(halted),  32'd0);
        chk("rst_alu",     32'(alu_op),  32'd0);
        chk_en = 1'b1;

        // All-NOP ROM: ir_load on fetch cycles, pc_inc on execute cycles, no pc_load
        start();
        for (int c = 1; c <= 3 * PER; c++) begin
            @(negedge clk);
            chk("nop_ir_load", 32'(ir_load), 32'(c % PER == 1));
            chk("nop_pc_inc",  32'(pc_inc),  32'(c >= 3 && (c - 3) % PER == 0));
            chk("nop_pc_load", 32'(pc_load), 32'd0);
        end

        // LDI 5, ADD 3, OUT, HLT
        fill(8'h00);
        rom[0] = 8'h15; rom[1] = 8'h23; rom[2] = 8'h40; rom[3] = 8'hF0;
        start();
        cyc(3);
        chk("ldi_acc_load", 32'(acc_load), 32'd1);
        chk("ldi_alu",      32'(alu_op),   32'd0);
        chk("ldi_operand",  32'(operand),  32'd5);
        cyc(PER);
        chk("add_acc_load", 32'(acc_load), 32'd1);
        chk("add_alu",      32'(alu_op),   32'd1);
        chk("add_operand",  32'(operand),  32'd3);
        cyc(PER);
        chk("out_load",     32'(out_load), 32'd1);
        cyc(PER);
        chk("hlt_pc_inc",   32'(pc_inc),   32'd0);
        chk("hlt_pc_load",  32'(pc_load),  32'd0);
        cyc(1);
        chk("hlt_halted",   32'(halted),   32'd1);
        chk("hlt_state",    32'(state),    32'd3);
        chk("out_value",    32'(out_r),    32'd8);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hlt_quiet", 32'({ir_load, pc_inc, pc_load, acc_load, out_load, alu_op}), 32'd0);
        end
        chk("hlt_pc_frozen", 32'(pc_r), 32'd3);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("hlt_rst_halted", 32'(halted), 32'd0);
        chk("hlt_rst_state",  32'(state),  32'd0);

        // JMP 9
        fill(8'h00);
        rom[0] = 8'h59;
        start();
        cyc(3);
        chk("jmp_pc_load", 32'(pc_load), 32'd1);
        chk("jmp_pc_inc",  32'(pc_inc),  32'd0);
        chk("jmp_operand", 32'(operand), 32'd9);
        cyc(PER);
        chk("jmp_pc",      32'(pc_r),    32'd9);

        // JZ taken: LDI 0, JZ C
        fill(8'h00);
        rom[0] = 8'h10; rom[1] = 8'h6C;
        start();
        cyc(PER + 3);
        chk("jz_t_pc_load", 32'(pc_load), 32'd1);
        chk("jz_t_pc_inc",  32'(pc_inc),  32'd0);
        chk("jz_t_operand", 32'(operand), 32'd12);
        cyc(PER);
        chk("jz_t_pc",      32'(pc_r),    32'd12);

        // JZ not taken: LDI 1, JZ C
        rom[0] = 8'h11;
        start();
        cyc(PER + 3);
        chk("jz_n_pc_load", 32'(pc_load), 32'd0);
        chk("jz_n_pc_inc",  32'(pc_inc),  32'd1);
        cyc(PER);
        chk("jz_n_pc",      32'(pc_r),    32'd2);

        // Reset pulsed mid-DECODE
        fill(8'h15);
        start();
        cyc(1);
        @(posedge clk);
        #1;
        chk("mid_state_pre",   32'(state),   32'd1);
        chk("mid_operand_pre", 32'(operand), 32'd5);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_state",   32'(state),   32'd0);
        chk("mid_operand", 32'(operand), 32'd0);
        chk("mid_ir_load", 32'(ir_load), 32'd0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        cyc(1);
        chk("mid_restart", 32'(ir_load), 32'd1);

`ifdef CTRL_STEP_EN
        // Single-step: NOP then park in WAIT until step
        fill(8'h00);
        step = 1'b0;
        start();
        cyc(3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("wait_state", 32'(state), 32'd4);
            chk("wait_quiet", 32'({ir_load, pc_inc, pc_load, acc_load, out_load, alu_op}), 32'd0);
        end
        step = 1'b1;
        cyc(1);
        chk("step_fetch", 32'(state), 32'd0);
        chk("step_ir",    32'(ir_load), 32'd1);
`endif

        // Randomized programs with occasional asynchronous resets
        for (int run = 0; run < 30; run++) begin
            for (int a = 0; a < 16; a++) begin
                int unsigned op;
                op = $urandom_range(0, 15);
                if (op == 15 && $urandom_range(0, 3) != 0) op = $urandom_range(0, 6);
                rom[a] = {4'(op), 4'($urandom_range(0, 15))};
            end
            start();
            for (int c = 0; c < int'($urandom_range(40, 150)); c++) begin
                @(posedge clk);
                #2;
`ifdef CTRL_STEP_EN
                step = ($urandom_range(0, 2) == 0);
`endif
                if ($urandom_range(0, 59) == 0) begin
                    #($urandom_range(0, 5)) reset_n = 1'b0;
                    @(posedge clk);
                    #2 reset_n = 1'b1;
                end
            end
        end

        cyc(2);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction sequencer for the 4-bit CPU. It fetches an 8-bit instruction from program ROM at the current `program_counter` address, then decodes and executes it. It drives the PC strobes (`pc_inc`, `pc_load`, jump target) and the accumulator and ALU controls. It sits between program ROM, `program_counter`, and the ALU/accumulator datapath, and is the only block that writes the PC.

## Interface
- `OPC_W`, default 4: opcode width, `instr[7:4]`.
- `ADDR_W`, default 4: PC and operand width, `instr[3:0]`.
- `clk`, input, 1: rising-edge clock.
- `reset_n`, input, 1: reset, asynchronous, active-low.
- `instr`, input, 8: ROM data at the address on `pc_out`.
- `zero_flag`, input, 1: accumulator == 0, from the datapath.
- `ir_load`, output, 1: instruction register capture strobe (informational).
- `pc_inc`, output, 1: PC increment strobe.
- `pc_load`, output, 1: PC load strobe.
- `operand`, output, `ADDR_W`: `IR[3:0]`. Used as the jump target (`pc_in`) and as the immediate.
- `alu_op`, output, 2: 00 PASS, 01 ADD, 10 SUB, 11 reserved.
- `acc_load`, output, 1: accumulator write strobe.
- `out_load`, output, 1: output register write strobe.
- `halted`, output, 1: high while in HALT.
- `state`, output, 3: current FSM state (debug).
- `step`, input, 1: present only with `CTRL_STEP_EN`.

## Operation
- Internal 8-bit IR, captured from `instr` in FETCH.
- FSM states: FETCH=0, DECODE=1, EXECUTE=2, HALT=3, WAIT=4.
  - FETCH -> DECODE, with `ir_load`=1.
  - DECODE -> EXECUTE; no strobes.
  - EXECUTE -> FETCH, or -> HALT for HLT.
  - HALT: absorbing until reset.
- Opcodes:
  - 0 NOP: no action.
  - 1 LDI: `alu_op`=PASS, `acc_load`.
  - 2 ADD: `alu_op`=ADD, `acc_load`.
  - 3 SUB: `alu_op`=SUB, `acc_load`.
  - 4 OUT: `out_load`.
  - 5 JMP: `pc_load`.
  - 6 JZ: `pc_load` if `zero_flag`, else `pc_inc`.
  - F HLT: to HALT.
  - 7–E: treated as NOP.
- EXECUTE strobes:
  - Exactly one of `pc_inc`/`pc_load` is 1, except for HLT, where both are 0 and the PC freezes on the HLT address.
  - `pc_inc` and `pc_load` are never high together.
- All strobes are single-cycle and decoded from the state register and IR only. The one exception: `zero_flag` feeds `pc_load`/`pc_inc` combinationally during EXECUTE of JZ.
- `operand` always reflects `IR[3:0]`.
- `alu_op` is 00 outside EXECUTE.

## Timing
- Reset (`reset_n`=0, async):
  - state=FETCH, IR=0x00.
  - All strobes 0, `alu_op`=00, `halted`=0, `operand`=0.
- First `ir_load` is in the first cycle after `reset_n` rises.
- Every instruction takes 3 cycles (FETCH, DECODE, EXECUTE). The PC updates on the clock edge ending EXECUTE.
- `zero_flag` is sampled in the EXECUTE cycle of JZ. It reflects the accumulator as of the previous instruction's write.
- PC wrap (0xF + 1 -> 0x0) is handled by `program_counter`; the controller does nothing special.
- `reset_n` asserted mid-instruction aborts it immediately. No partial strobe survives.
- In HALT: `halted`=1 and all strobes are 0 indefinitely.

## Configuration
- `CTRL_STEP_EN` defined:
  - Adds the `step` input and the WAIT state.
  - EXECUTE (non-HLT) -> WAIT.
  - WAIT -> FETCH on the first cycle with `step`=1, sampled as a level. No strobes in WAIT.
  - Minimum instruction period becomes 4 cycles.
- `CTRL_STEP_EN` undefined:
  - No `step` port.
  - State encoding 4 is unreachable.
  - EXECUTE -> FETCH directly.

## Structure
- `cpu_pkg` holds:
  - opcode localparams (`OP_NOP`..`OP_HLT`);
  - `alu_op` encodings;
  - state encodings;
  - `OPC_W`/`ADDR_W` defaults.
- One sub-module, `instr_decoder`: combinational, maps opcode, state and `zero_flag` to the strobe set.
- FSM and IR stay in `control_unit`.

## Test plan
- Reset release with ROM=0x00 everywhere:
  - `ir_load` pulses every 3 cycles;
  - `pc_inc` is high on cycles 3, 6, 9…;
  - `pc_load` is never high.
- LDI 5 (0x15), ADD 3 (0x23): `acc_load` in both EXECUTE cycles, `alu_op` 00 then 01, `operand` 5 then 3.
- JMP 9 (0x59): in EXECUTE `pc_load`=1, `operand`=9, `pc_inc`=0. The next FETCH sees the PC at 9.
- JZ 0xC (0x6C):
  - `zero_flag`=1 -> `pc_load`=1, `operand`=0xC;
  - `zero_flag`=0 -> `pc_inc`=1 only.
- HLT (0xF0): after EXECUTE, `halted`=1 and `state`=3. There are no strobes for 20 cycles. `reset_n` low then returns the block to FETCH with `halted`=0.
- `reset_n` pulsed low mid-DECODE: outputs clear asynchronously in the same cycle, and the block restarts from FETCH.
- With `CTRL_STEP_EN`: after NOP the block sits in WAIT with no strobes until `step`=1, then FETCH follows on the next cycle.
